// File: rtl/fpu_bus_master.sv
// fpu_bus_master
//   Upstream driver for the FPU 8-bit register port. Takes one operand pair
//   and an operation byte over a valid/ready request channel, runs the whole
//   FPU command sequence and returns the 32-bit result over a valid/ready
//   response channel:
//     write A (addr 0..3) and B (addr 4..7) bytes little-endian, op (addr 8),
//     start (addr 9 = 8'h00), wait for cmd_end, read result bytes from
//     addr 9..C, run the end_ack handshake, present the response.
//
//   Ports
//     clk, arst_n                  clock, asynchronous active-low reset
//     req_valid/req_ready          request handshake (req_op, req_a, req_b)
//     rsp_valid/rsp_ready          response handshake (rsp_result, rsp_timeout)
//     fpu_cs/fpu_rd/fpu_wr         active-low bus controls to the fpu
//     fpu_addr, fpu_wdata          register address and write data
//     fpu_rdata                    read data from the fpu
//     fpu_end_ack                  end-of-command acknowledge (active high)
//     fpu_cmd_end, fpu_busy        fpu status inputs
//
//   Parameters
//     WR_LOW_CYCLES   cycles fpu_wr is held low per write (>=1)
//     RD_WAIT_CYCLES  cycles fpu_rd is low before data is sampled (>=1);
//                     the rd-low window is RD_WAIT_CYCLES+1 cycles
//     TIMEOUT_CYCLES  cmd_end / end_ack wait limit
//
//   Build option
//     FPU_TIMEOUT_EN  when defined, WAIT and ACK are bounded by
//                     TIMEOUT_CYCLES and rsp_timeout reports an abandoned
//                     command; otherwise both wait indefinitely and
//                     rsp_timeout is tied low.
module fpu_bus_master #(
  parameter int WR_LOW_CYCLES  = 1,
  parameter int RD_WAIT_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic        fpu_cs,
  output logic        fpu_rd,
  output logic        fpu_wr,
  output logic [3:0]  fpu_addr,
  output logic [7:0]  fpu_wdata,
  input  logic [7:0]  fpu_rdata,
  output logic        fpu_end_ack,
  input  logic        fpu_cmd_end,
  input  logic        fpu_busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_BUSYCHK, S_WRITE, S_WAIT, S_READ, S_ACK, S_RSP
  } state_t;

  typedef enum logic [1:0] {PH_SETUP, PH_STROBE, PH_RECOVER} phase_t;

  localparam int PH_MAX = (WR_LOW_CYCLES > RD_WAIT_CYCLES) ? WR_LOW_CYCLES : RD_WAIT_CYCLES;
  localparam int PW     = $clog2(PH_MAX + 1);
  localparam logic [PW-1:0] WR_LAST = PW'(WR_LOW_CYCLES - 1);
  localparam logic [PW-1:0] RD_LAST = PW'(RD_WAIT_CYCLES);

  state_t          state;
  phase_t          phase;
  logic [PW-1:0]   ph_cnt;
  logic [3:0]      idx;       // write access 0..9, read access 0..3
  logic [31:0]     a_q, b_q;
  logic [7:0]      op_q;
  logic [79:0]     wr_vec;
  logic [3:0]      idx_next;

  // Byte stream for the ten write accesses, byte n goes to address n.
  assign wr_vec   = {8'h00, op_q, b_q, a_q};
  assign idx_next = idx + 4'd1;

  // Ready is combinational so that a new request can be taken on the very
  // edge that hands off the previous response.
  assign req_ready = (state == S_IDLE) || ((state == S_RSP) && rsp_ready);

`ifdef FPU_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
`else
  assign rsp_timeout = 1'b0;
`endif

  // NOTE: every register below is updated with non-blocking assignments so
  // that all state sampled in one edge sees the pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state       <= S_IDLE;
      phase       <= PH_SETUP;
      ph_cnt      <= '0;
      idx         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      fpu_cs      <= 1'b1;
      fpu_rd      <= 1'b1;
      fpu_wr      <= 1'b1;
      fpu_addr    <= '0;
      fpu_wdata   <= '0;
      fpu_end_ack <= 1'b0;
`ifdef FPU_TIMEOUT_EN
      rsp_timeout <= 1'b0;
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_RSP: begin
          if (state == S_RSP && rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
          if (req_valid && req_ready) begin
            a_q   <= req_a;
            b_q   <= req_b;
            op_q  <= req_op;
            state <= S_BUSYCHK;
`ifdef FPU_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
          end
        end

        S_BUSYCHK: begin
          if (!fpu_busy) begin
            state     <= S_WRITE;
            phase     <= PH_SETUP;
            idx       <= '0;
            fpu_cs    <= 1'b0;
            fpu_addr  <= 4'd0;
            fpu_wdata <= a_q[7:0];
          end
        end

        S_WRITE: begin
          case (phase)
            PH_SETUP: begin
              fpu_wr <= 1'b0;
              ph_cnt <= '0;
              phase  <= PH_STROBE;
            end
            PH_STROBE: begin
              if (ph_cnt == WR_LAST) begin
                fpu_wr <= 1'b1;
                phase  <= PH_RECOVER;
              end else begin
                ph_cnt <= ph_cnt + 1'b1;
              end
            end
            default: begin
              if (idx == 4'd9) begin
                fpu_cs <= 1'b1;
                state  <= S_WAIT;
`ifdef FPU_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
              end else begin
                idx       <= idx_next;
                fpu_addr  <= idx_next;
                fpu_wdata <= wr_vec[{idx_next, 3'b000} +: 8];
                phase     <= PH_SETUP;
              end
            end
          endcase
        end

        S_WAIT: begin
          // cmd_end is only looked at here; a level left over from an earlier
          // command is taken as completion.
          if (fpu_cmd_end) begin
            state    <= S_READ;
            phase    <= PH_STROBE;
            ph_cnt   <= '0;
            idx      <= '0;
            fpu_cs   <= 1'b0;
            fpu_rd   <= 1'b0;
            fpu_addr <= 4'h9;
          end
`ifdef FPU_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            state       <= S_RSP;
            rsp_valid   <= 1'b1;
            rsp_result  <= 32'h7FC0_0000;
            rsp_timeout <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        S_READ: begin
          if (phase == PH_STROBE) begin
            if (ph_cnt == RD_LAST) begin
              rsp_result[{idx[1:0], 3'b000} +: 8] <= fpu_rdata;
              fpu_rd <= 1'b1;
              phase  <= PH_RECOVER;
            end else begin
              ph_cnt <= ph_cnt + 1'b1;
            end
          end else if (idx == 4'd3) begin
            fpu_cs      <= 1'b1;
            fpu_end_ack <= 1'b1;
            state       <= S_ACK;
`ifdef FPU_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
          end else begin
            idx      <= idx_next;
            fpu_addr <= fpu_addr + 4'd1;
            fpu_rd   <= 1'b0;
            ph_cnt   <= '0;
            phase    <= PH_STROBE;
          end
        end

        S_ACK: begin
          if (!fpu_cmd_end) begin
            fpu_end_ack <= 1'b0;
            rsp_valid   <= 1'b1;
            state       <= S_RSP;
          end
`ifdef FPU_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            fpu_end_ack <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= S_RSP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
